// File: rtl/prescaled_updown_counter_pkg.sv
// prescaled_updown_counter_pkg: shared direction and limit-mode constants
package prescaled_updown_counter_pkg;
  localparam logic UP = 1'b1;
  localparam logic DOWN = 1'b0;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
endpackage

// File: rtl/prescaled_updown_counter_prescale_tick.sv
// prescale_tick: emits a step every prescaler+1 enabled cycles
module prescale_tick #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescaler,
  output logic             step
);
  logic [PRE_W-1:0] pc;
  assign step = en && !clr && (pc >= prescaler);
  // pc restarts on clear or step; a lowered prescaler below pc steps immediately
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= '0;
    else if (clr || step) pc <= '0;
    else if (en) pc <= pc + 1'b1;
endmodule

// File: rtl/prescaled_updown_counter.sv
// prescaled_updown_counter: prescaled up/down counter with wrap or saturate limits
module prescaled_updown_counter
  import prescaled_updown_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PRE_W = 16,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PRE_W-1:0] prescaler,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] Q,
  output logic             tick,
  output logic             tc
);
  localparam logic SAT = (SATURATE == MODE_SAT);
  logic step, lim;
  logic [WIDTH-1:0] nxt;
  prescale_tick #(.PRE_W(PRE_W)) u_pre (
    .clk(clk), .reset(reset), .en(en), .clr(load), .prescaler(prescaler), .step(step)
  );
  // limit detection and next count value for the current direction
  always_comb begin
    lim = (dir == UP) ? (Q >= max_val) : (Q == '0 || Q > max_val);
    nxt = (dir == UP) ? (lim ? (SAT ? max_val : '0) : Q + 1'b1)
        : (Q > max_val) ? max_val
        : lim ? (SAT ? '0 : max_val) : Q - 1'b1;
  end
  // counter register: load clamps to max_val and wins over stepping
  always_ff @(posedge clk or posedge reset)
    if (reset) Q <= '0;
    else if (load) Q <= (load_val > max_val) ? max_val : load_val;
    else if (step) Q <= nxt;
  // strobes follow the step by one cycle; step is already masked by load
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tick <= 1'b0;
      tc <= 1'b0;
    end else begin
      tick <= step;
      tc <= step && lim;
    end
endmodule

// File: tb/tb_prescaled_updown_counter.sv
// tb_prescaled_updown_counter: wrap and saturate counters against a behavioural model
module tb_prescaled_updown_counter;
  logic clk = 0, reset = 1, en = 0, dir = 1, load = 0;
  logic [3:0] load_val = 0, max_val = 15;
  logic [15:0] prescaler = 0;
  logic [3:0] q_w, q_s;
  logic tick_w, tick_s, tc_w, tc_s;
  int total = 0, bad = 0;
  int m_pc = 0;
  int m_q[2] = '{0, 0};
  bit m_tick[2] = '{0, 0};
  bit m_tc[2] = '{0, 0};

  prescaled_updown_counter #(.WIDTH(4), .PRE_W(16), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .prescaler(prescaler), .max_val(max_val), .Q(q_w), .tick(tick_w), .tc(tc_w));
  prescaled_updown_counter #(.WIDTH(4), .PRE_W(16), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .prescaler(prescaler), .max_val(max_val), .Q(q_s), .tick(tick_s), .tc(tc_s));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic void next_q(input int q, input bit up, input int mx, input bit sat,
                                 output int nq, output bit lim);
    if (up) begin
      lim = q >= mx;
      nq = lim ? (sat ? mx : 0) : q + 1;
    end else if (q > mx) begin
      lim = 1;
      nq = mx;
    end else if (q == 0) begin
      lim = 1;
      nq = sat ? 0 : mx;
    end else begin
      lim = 0;
      nq = q - 1;
    end
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_pc = 0;
      for (int s = 0; s < 2; s++) begin m_q[s] = 0; m_tick[s] = 0; m_tc[s] = 0; end
    end else if (load) begin
      m_pc = 0;
      for (int s = 0; s < 2; s++) begin
        m_q[s] = (int'(load_val) < int'(max_val)) ? int'(load_val) : int'(max_val);
        m_tick[s] = 0;
        m_tc[s] = 0;
      end
    end else if (en) begin
      bit st;
      st = m_pc >= int'(prescaler);
      m_pc = st ? 0 : m_pc + 1;
      for (int s = 0; s < 2; s++) begin
        int nq;
        bit lm;
        next_q(m_q[s], dir, int'(max_val), s == 1, nq, lm);
        m_tick[s] = st;
        m_tc[s] = st && lm;
        if (st) m_q[s] = nq;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin m_tick[s] = 0; m_tc[s] = 0; end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("model_q_wrap", int'(q_w), m_q[0]);
    chk("model_tick_wrap", int'(tick_w), int'(m_tick[0]));
    chk("model_tc_wrap", int'(tc_w), int'(m_tc[0]));
    chk("model_q_sat", int'(q_s), m_q[1]);
    chk("model_tick_sat", int'(tick_s), int'(m_tick[1]));
    chk("model_tc_sat", int'(tc_s), int'(m_tc[1]));
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sq[4] = '{1, 0, 0, 0};
    int stc[4] = '{0, 0, 1, 1};
    int wq[4] = '{1, 0, 15, 14};
    int wtc[4] = '{0, 0, 1, 0};
    repeat (2) edge1();
    chk("reset_q", int'(q_w), 0);
    chk("reset_tick", int'(tick_w), 0);
    chk("reset_tc", int'(tc_s), 0);
    prescaler = 3; en = 1; dir = 1; max_val = 15; reset = 0;
    for (int k = 1; k <= 16; k++) begin
      repeat (3) begin edge1(); chk("up_idle_tick", int'(tick_w), 0); end
      edge1();
      chk("up_tick", int'(tick_w), 1);
      chk("up_q_wrap", int'(q_w), k % 16);
      chk("up_tc_wrap", int'(tc_w), int'(k == 16));
      chk("up_q_sat", int'(q_s), k > 15 ? 15 : k);
    end
    load = 1; max_val = 9; load_val = 12;
    edge1();
    chk("load_clamp_w", int'(q_w), 9);
    chk("load_clamp_s", int'(q_s), 9);
    chk("load_tick", int'(tick_w), 0);
    load = 0; prescaler = 0; dir = 1;
    edge1();
    chk("load_up_q_w", int'(q_w), 0);
    chk("load_up_tc_w", int'(tc_w), 1);
    chk("load_up_q_s", int'(q_s), 9);
    chk("load_up_tc_s", int'(tc_s), 1);
    load = 1; load_val = 2; max_val = 15;
    edge1();
    load = 0; dir = 0;
    for (int i = 0; i < 4; i++) begin
      edge1();
      chk("down_q_s", int'(q_s), sq[i]);
      chk("down_tc_s", int'(tc_s), stc[i]);
      chk("down_q_w", int'(q_w), wq[i]);
      chk("down_tc_w", int'(tc_w), wtc[i]);
    end
    load = 1; load_val = 12; max_val = 15;
    edge1();
    load = 0; max_val = 5; dir = 0;
    edge1();
    chk("above_max_q_w", int'(q_w), 5);
    chk("above_max_tc_w", int'(tc_w), 1);
    chk("above_max_q_s", int'(q_s), 5);
    chk("above_max_tc_s", int'(tc_s), 1);
    prescaler = 7; dir = 1; max_val = 15; load = 1; load_val = 3;
    edge1();
    load = 0;
    repeat (5) edge1();
    #3 reset = 1;
    #1;
    chk("async_reset_q", int'(q_w), 0);
    chk("async_reset_tick", int'(tick_w), 0);
    edge1();
    reset = 0;
    for (int i = 1; i <= 8; i++) begin
      edge1();
      chk("post_reset_tick", int'(tick_w), int'(i == 8));
    end
    load = 1; load_val = 4;
    edge1();
    load = 0;
    repeat (2) edge1();
    en = 0;
    for (int i = 0; i < 10; i++) begin
      edge1();
      chk("freeze_tick", int'(tick_w), 0);
      chk("freeze_q", int'(q_w), 4);
    end
    en = 1;
    for (int i = 1; i <= 6; i++) begin
      edge1();
      chk("resume_tick", int'(tick_w), int'(i == 6));
    end
    chk("resume_q", int'(q_w), 5);
    for (int c = 0; c < 3000; c++) begin
      edge1();
      en = $urandom_range(0, 9) != 0;
      dir = $urandom_range(0, 1) == 1;
      load = $urandom_range(0, 19) == 0;
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) max_val = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) prescaler = 16'($urandom_range(0, 5));
      if (reset) reset = 0;
      else if ($urandom_range(0, 199) == 0) begin #2 reset = 1; end
    end
    reset = 0;
    repeat (2) edge1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
